// File: rtl/fp_norm_round_pipe.sv
// Three-stage normalize/round pipeline: two's-complement mantissa + biased exponent -> packed FP.
// Define FP_NORM_ROUND_STICKY_FLAGS_EN to enable the accumulating flags_sticky register.
module fp_norm_round_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [MAN_W+4:0]       in_mant,
  input  logic [EXP_W-1:0]       in_exp,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_r,
  output logic [2:0]             out_flags,
  output logic [2:0]             flags_sticky,
  input  logic                   flags_clr
);

  localparam int unsigned M     = MAN_W + 5;
  localparam int unsigned MAG_W = M - 1;       // carry..sticky
  localparam int unsigned NRM_W = M - 2;       // hidden..sticky
  localparam int unsigned EW    = EXP_W + 2;
  localparam int unsigned FR_W  = MAN_W + 1;
  localparam int unsigned LZ_W  = $clog2(NRM_W + 1);
  localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;

  logic                   rdy_q, rdy_d;
  logic                   v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic                   sign1_q, sign1_d, sign2_q, sign2_d;
  logic [MAG_W-1:0]       mag1_q, mag1_d;
  logic [EXP_W-1:0]       exp1_q, exp1_d;
  logic [NRM_W-1:0]       nrm2_q, nrm2_d;
  logic signed [EW-1:0]   exp2_q, exp2_d;
  logic [EXP_W+MAN_W:0]   r3_q, r3_d;
  logic [2:0]             flg3_q, flg3_d;

  logic                   ld1_c, ld2_c, ld3_c, acc_c;
  logic [LZ_W-1:0]        lzc;
  logic                   lz_found;
  logic                   round_up, inexact;
  logic [FR_W-1:0]        frac_rnd;
  logic signed [EW-1:0]   exp_fin;

  // A stage loads when empty or when its downstream stage loads.
  assign ld3_c    = !v3_q || out_ready;
  assign ld2_c    = !v2_q || ld3_c;
  assign ld1_c    = !v1_q || ld2_c;
  assign in_ready = rdy_q && ld1_c;
  assign acc_c    = in_valid && in_ready;

  assign out_valid = v3_q;
  assign out_r     = r3_q;
  assign out_flags = flg3_q;

  always_comb begin
    rdy_d    = 1'b1;
    v1_d     = ld1_c ? acc_c : v1_q;
    v2_d     = ld2_c ? v1_q  : v2_q;
    v3_d     = ld3_c ? v2_q  : v3_q;
    sign1_d  = sign1_q;
    mag1_d   = mag1_q;
    exp1_d   = exp1_q;
    sign2_d  = sign2_q;
    nrm2_d   = nrm2_q;
    exp2_d   = exp2_q;
    r3_d     = r3_q;
    flg3_d   = flg3_q;
    lzc      = '0;
    lz_found = 1'b0;

    // S1: sign / magnitude
    if (acc_c) begin
      sign1_d = in_mant[M-1];
      mag1_d  = in_mant[M-1] ? MAG_W'(~in_mant[M-2:0] + MAG_W'(1)) : in_mant[M-2:0];
      exp1_d  = in_exp;
    end

    // S2: leading-zero count below the carry bit, then normalize
    for (int i = NRM_W - 1; i >= 0; i--) begin
      if (!lz_found && mag1_q[i]) begin
        lzc      = LZ_W'(NRM_W - 1 - i);
        lz_found = 1'b1;
      end
    end
    if (ld2_c && v1_q) begin
      sign2_d = sign1_q;
      if (mag1_q[MAG_W-1]) begin
        nrm2_d = {mag1_q[MAG_W-1:2], |mag1_q[1:0]};
        exp2_d = EW'({2'b00, exp1_q}) + EW'(1);
      end else begin
        nrm2_d = NRM_W'(mag1_q[NRM_W-1:0] << lzc);
        exp2_d = EW'({2'b00, exp1_q}) - EW'(lzc);
      end
    end

    // S3: round to nearest-even, then range check on the final exponent
    round_up = nrm2_q[1] && (nrm2_q[0] || nrm2_q[2]);
    inexact  = nrm2_q[1] || nrm2_q[0];
    frac_rnd = {1'b0, nrm2_q[NRM_W-2:2]} + FR_W'(round_up);
    exp_fin  = exp2_q + EW'(frac_rnd[MAN_W]);
    if (ld3_c && v2_q) begin
      if (!nrm2_q[NRM_W-1]) begin
        r3_d   = '0;
        flg3_d = 3'b000;
      end else if (exp_fin >= EXP_MAX) begin
        r3_d   = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        flg3_d = 3'b101;
      end else if (exp_fin <= EXP_ZERO) begin
        r3_d   = {sign2_q, {(EXP_W + MAN_W){1'b0}}};
        flg3_d = 3'b011;
      end else begin
        r3_d   = {sign2_q, exp_fin[EXP_W-1:0], frac_rnd[MAN_W-1:0]};
        flg3_d = {2'b00, inexact};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q   <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      sign1_q <= 1'b0;
      mag1_q  <= '0;
      exp1_q  <= '0;
      sign2_q <= 1'b0;
      nrm2_q  <= '0;
      exp2_q  <= '0;
      r3_q    <= '0;
      flg3_q  <= '0;
    end else begin
      rdy_q   <= rdy_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      sign1_q <= sign1_d;
      mag1_q  <= mag1_d;
      exp1_q  <= exp1_d;
      sign2_q <= sign2_d;
      nrm2_q  <= nrm2_d;
      exp2_q  <= exp2_d;
      r3_q    <= r3_d;
      flg3_q  <= flg3_d;
    end
  end

`ifdef FP_NORM_ROUND_STICKY_FLAGS_EN
  logic [2:0] sticky_q, sticky_d;

  // A handshake in the same cycle as a clear still lands its flags.
  always_comb begin
    sticky_d = flags_clr ? 3'b000 : sticky_q;
    if (v3_q && out_ready) sticky_d = sticky_d | flg3_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= 3'b000;
    else        sticky_q <= sticky_d;
  end

  assign flags_sticky = sticky_q;
`else
  logic unused_flags_clr;
  assign unused_flags_clr = flags_clr;
  assign flags_sticky     = 3'b000;
`endif

endmodule

// File: tb/tb_fp_norm_round_pipe.sv
// Self-checking bench for fp_norm_round_pipe: directed vectors, backpressure, reset and random traffic
// against an arithmetic reference model.
module tb_fp_norm_round_pipe;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam int unsigned M     = MAN_W + 5;
  localparam int unsigned R_W   = 1 + EXP_W + MAN_W;
`ifdef FP_NORM_ROUND_STICKY_FLAGS_EN
  localparam logic [2:0] STK_AFTER_OVF = 3'b101;
  localparam logic [2:0] STK_AFTER_CLR = 3'b001;
`else
  localparam logic [2:0] STK_AFTER_OVF = 3'b000;
  localparam logic [2:0] STK_AFTER_CLR = 3'b000;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [M-1:0]     in_mant = '0;
  logic [EXP_W-1:0] in_exp = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [R_W-1:0]   out_r;
  logic [2:0]       out_flags;
  logic [2:0]       flags_sticky;
  logic             flags_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_norm_round_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mant(in_mant), .in_exp(in_exp),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_flags(out_flags),
    .flags_sticky(flags_sticky), .flags_clr(flags_clr)
  );

  // Reference: exact integer magnitude, round-to-nearest-even to 24 significant bits.
  function automatic void ref_model(input logic [M-1:0] mant, input logic [EXP_W-1:0] ein,
                                    output logic [R_W-1:0] r, output logic [2:0] f);
    logic   sgn, inx;
    longint mag, q, rem, half;
    int     p, sh, e;
    sgn = mant[M-1];
    mag = sgn ? ((longint'(1) << M) - longint'(mant)) : longint'(mant);
    r = '0;
    f = 3'b000;
    if (mag == 0) return;
    p = 0;
    for (int i = 0; i < 63; i++) if (mag[i]) p = i;
    sh  = p - int'(MAN_W);
    inx = 1'b0;
    if (sh > 0) begin
      q    = mag >> sh;
      rem  = mag & ((longint'(1) << sh) - 1);
      half = longint'(1) << (sh - 1);
      inx  = (rem != 0);
      if (rem > half || (rem == half && q[0])) q = q + 1;
    end else begin
      q = mag << (-sh);
    end
    e = int'(ein) + p - int'(MAN_W + 2);
    if (q == (longint'(1) << (MAN_W + 1))) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= (1 << EXP_W) - 1) begin
      r = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      f = 3'b101;
    end else if (e <= 0) begin
      r = {sgn, {(EXP_W + MAN_W){1'b0}}};
      f = 3'b011;
    end else begin
      r = {sgn, EXP_W'(e), MAN_W'(q)};
      f = {2'b00, inx};
    end
  endfunction

  function automatic logic [M-1:0] rand_mant();
    logic [M-1:0] m;
    m = M'($urandom) >> $urandom_range(1, M);
    if ($urandom_range(0, 1) == 1) m = M'(~m + M'(1));
    return m;
  endfunction

  function automatic logic [EXP_W-1:0] rand_exp();
    if ($urandom_range(0, 1) == 1) return EXP_W'($urandom_range(0, (1 << EXP_W) - 1));
    return EXP_W'($urandom_range(100, 160));
  endfunction

  task automatic test_reset();
    #1 rst_n = 1'b0;
    in_valid = 1'b1;
    in_mant  = 28'h2000000;
    in_exp   = 8'd127;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (out_r !== '0 || out_flags !== 3'b000) begin errors++; $display("FAIL rst_out_data: got %h/%b want 0/0", out_r, out_flags); end
    checks++; if (flags_sticky !== 3'b000) begin errors++; $display("FAIL rst_sticky: got %b want 000", flags_sticky); end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_rise_ready: got %b want 0", in_ready); end
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_first_edge_ready: got %b want 1", in_ready); end
    out_ready = 1'b1;
  endtask

  task automatic test_directed();
    logic [M-1:0]     dm [14] = '{28'h2000000, 28'h4000000, 28'hE000000, 28'h2000002, 28'h2000006,
                                  28'h3FFFFFE, 28'h4000000, 28'h0000004, 28'h0000000, 28'hFFFFFFF,
                                  28'h2000000, 28'h1000000, 28'h2000000, 28'h3FFFFFE};
    logic [EXP_W-1:0] de [14] = '{8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd254, 8'd10,
                                  8'd200, 8'd127, 8'd1, 8'd1, 8'd254, 8'd254};
    logic [R_W-1:0]   dr [14] = '{32'h3F800000, 32'h40000000, 32'hBF800000, 32'h3F800000, 32'h3F800002,
                                  32'h40000000, 32'h7F800000, 32'h00000000, 32'h00000000, 32'hB3000000,
                                  32'h00800000, 32'h00000000, 32'h7F000000, 32'h7F800000};
    logic [2:0]       df [14] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b001, 3'b101, 3'b011,
                                  3'b000, 3'b000, 3'b000, 3'b011, 3'b000, 3'b101};
    int lat;
    for (int v = 0; v < 14; v++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_mant   = dm[v];
      in_exp    = de[v];
      lat = 0;
      do begin
        @(posedge clk);
        lat++;
        @(negedge clk);
        in_valid = 1'b0;
      end while (!out_valid && lat < 10);
      checks++; if (lat != 3) begin errors++; $display("FAIL dir%0d_latency: got %0d want 3", v, lat); end
      checks++; if (out_r !== dr[v]) begin errors++; $display("FAIL dir%0d_result: got %h want %h", v, out_r, dr[v]); end
      checks++; if (out_flags !== df[v]) begin errors++; $display("FAIL dir%0d_flags: got %b want %b", v, out_flags, df[v]); end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [M-1:0]     bm [5];
    logic [EXP_W-1:0] be [5];
    logic [R_W-1:0]   er, held;
    logic [2:0]       ef;
    int acc = 0;
    int got = 0;
    for (int i = 0; i < 5; i++) begin
      bm[i] = rand_mant();
      be[i] = EXP_W'($urandom_range(20, 230));
    end
    held = '0;
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      in_valid = (acc < 5);
      if (acc < 5) begin in_mant = bm[acc]; in_exp = be[acc]; end
      #1;
      if (in_valid && in_ready) acc++;
      if (c == 5) held = out_r;
      @(negedge clk);
    end
    #1;
    ref_model(bm[0], be[0], er, ef);
    checks++; if (acc != 3) begin errors++; $display("FAIL bp_accepted: got %0d want 3", acc); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b1 || out_r !== held) begin errors++; $display("FAIL bp_hold: got %b/%h want 1/%h", out_valid, out_r, held); end
    checks++; if (out_r !== er || out_flags !== ef) begin errors++; $display("FAIL bp_head: got %h/%b want %h/%b", out_r, out_flags, er, ef); end
    out_ready = 1'b1;
    for (int c = 0; c < 30 && got < 5; c++) begin
      in_valid = (acc < 5);
      if (acc < 5) begin in_mant = bm[acc]; in_exp = be[acc]; end
      #1;
      if (in_valid && in_ready) acc++;
      if (out_valid && out_ready) begin
        ref_model(bm[got], be[got], er, ef);
        checks++;
        if (out_r !== er || out_flags !== ef) begin
          errors++; $display("FAIL bp_release%0d: got %h/%b want %h/%b", got, out_r, out_flags, er, ef);
        end
        got++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (got != 5 || acc != 5) begin errors++; $display("FAIL bp_count: got %0d out %0d in want 5 5", got, acc); end
  endtask

  task automatic test_random(input int n_cycles);
    logic [R_W-1:0] q_r [$];
    logic [2:0]     q_f [$];
    logic [R_W-1:0] er, prev_r;
    logic [2:0]     ef;
    logic           stalled = 1'b0;
    for (int c = 0; c < n_cycles + 40; c++) begin
      @(negedge clk);
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || out_r !== prev_r) begin
          errors++; $display("FAIL rand_stall_hold: got %b/%h want 1/%h", out_valid, out_r, prev_r);
        end
      end
      in_valid  = (c < n_cycles) && ($urandom_range(0, 3) != 0);
      in_mant   = rand_mant();
      in_exp    = rand_exp();
      out_ready = (c >= n_cycles) || ($urandom_range(0, 3) != 0);
      #1;
      if (in_valid && in_ready) begin
        ref_model(in_mant, in_exp, er, ef);
        q_r.push_back(er);
        q_f.push_back(ef);
      end
      stalled = out_valid && !out_ready;
      prev_r  = out_r;
      if (out_valid && out_ready) begin
        checks++;
        if (q_r.size() == 0) begin
          errors++; $display("FAIL rand_extra: got %h want no output", out_r);
        end else begin
          er = q_r.pop_front();
          ef = q_f.pop_front();
          if (out_r !== er || out_flags !== ef) begin
            errors++; $display("FAIL rand_result: got %h/%b want %h/%b", out_r, out_flags, er, ef);
          end
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++; if (q_r.size() != 0) begin errors++; $display("FAIL rand_drain: got %0d pending want 0", q_r.size()); end
  endtask

  task automatic test_sticky();
    int n;
    @(negedge clk);
    out_ready = 1'b1;
    flags_clr = 1'b1;
    @(negedge clk);
    flags_clr = 1'b0;
    checks++; if (flags_sticky !== 3'b000) begin errors++; $display("FAIL stk_clear: got %b want 000", flags_sticky); end
    in_valid = 1'b1; in_mant = 28'h4000000; in_exp = 8'd254;
    n = 0;
    do begin @(posedge clk); @(negedge clk); in_valid = 1'b0; n++; end while (!out_valid && n < 10);
    @(negedge clk);
    checks++; if (flags_sticky !== STK_AFTER_OVF) begin errors++; $display("FAIL stk_overflow: got %b want %b", flags_sticky, STK_AFTER_OVF); end
    in_valid = 1'b1; in_mant = 28'h2000002; in_exp = 8'd127;
    n = 0;
    do begin @(posedge clk); @(negedge clk); in_valid = 1'b0; n++; end while (!out_valid && n < 10);
    flags_clr = 1'b1;
    @(negedge clk);
    flags_clr = 1'b0;
    checks++; if (flags_sticky !== STK_AFTER_CLR) begin errors++; $display("FAIL stk_clr_vs_update: got %b want %b", flags_sticky, STK_AFTER_CLR); end
  endtask

  task automatic test_reset_midflight();
    logic [R_W-1:0] er;
    logic [2:0]     ef;
    int acc = 0;
    int seen = 0;
    int lat;
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (acc < 3);
      in_mant  = rand_mant();
      in_exp   = 8'd120;
      #1;
      if (in_valid && in_ready) acc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (acc != 3) begin errors++; $display("FAIL mid_fill: got %0d want 3", acc); end
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_hs: got %b/%b want 0/0", in_ready, out_valid); end
    checks++; if (out_r !== '0 || out_flags !== 3'b000 || flags_sticky !== 3'b000) begin
      errors++; $display("FAIL mid_rst_data: got %h/%b/%b want 0/0/0", out_r, out_flags, flags_sticky);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_back: got %b want 1", in_ready); end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL mid_ghost: got %0d outputs want 0", seen); end
    in_valid = 1'b1; in_mant = 28'h2000006; in_exp = 8'd127;
    ref_model(in_mant, in_exp, er, ef);
    lat = 0;
    do begin @(posedge clk); lat++; @(negedge clk); in_valid = 1'b0; end while (!out_valid && lat < 10);
    checks++; if (lat != 3) begin errors++; $display("FAIL mid_latency: got %0d want 3", lat); end
    checks++; if (out_r !== er || out_flags !== ef) begin errors++; $display("FAIL mid_result: got %h/%b want %h/%b", out_r, out_flags, er, ef); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random(1500);
    test_sticky();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fp_norm_round_pipe.md
FP_NORM_ROUND_PIPE -- requirements
Module: fp_norm_round_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, meaning biased exponent width.
REQ-002 SHALL have parameter MAN_W, default 23, meaning stored fraction width; M = MAN_W+5 is the input mantissa width.
REQ-003 SHALL use one clock and an asynchronous active-low reset: clk (in, 1, rising-edge clock), then rst_n (in, 1, asynchronous active-low reset).
REQ-004 SHALL have in_valid (in, 1, input beat valid) and in_ready (out, 1, input accepted when in_valid and in_ready are both high).
REQ-005 SHALL have in_mant (in, M, two's complement, laid out as: [M-1] sign, [M-2] carry, [M-3] hidden, [M-4:2] fraction, [1] guard, [0] sticky).
REQ-006 SHALL have in_exp (in, EXP_W, biased exponent of the hidden-bit position).
REQ-007 SHALL have out_valid (out, 1, result valid) and out_ready (in, 1, result consumed when out_valid and out_ready are both high).
REQ-008 SHALL have out_r (out, 1+EXP_W+MAN_W, packed {sign, exponent, fraction}) and out_flags (out, 3, {overflow, underflow, inexact}).
REQ-009 SHALL have flags_sticky (out, 3) and flags_clr (in, 1); see Configuration.

Function
REQ-010 SHALL be a 3-stage pipeline: S1 sign/magnitude, S2 normalize, S3 round/pack; latency is exactly 3 cycles from acceptance to out_valid with out_ready held high.
REQ-011 SHALL sustain one result per cycle when out_ready is high.
REQ-012 SHALL give each stage a valid bit; a stage loads when it is empty or the downstream stage loads; S3 holds while out_valid=1 and out_ready=0.
REQ-013 SHALL drive in_ready = (S1 empty) or (S1 advances); bubbles SHALL collapse; no beat is dropped or duplicated.
REQ-014 SHALL have S1 take sign = in_mant[M-1] and magnitude = two's-complement negation when the sign is set.
REQ-015 SHALL have S2, when the carry bit is set, shift right 1 with the shifted-out bit ORed into sticky and add 1 to the exponent.
REQ-016 SHALL have S2, when the carry bit is clear, shift left by the leading-zero count below the carry bit and subtract that count from the exponent, computed in EXP_W+2-bit signed arithmetic.
REQ-017 SHALL output +0 with all flags clear for a zero magnitude, regardless of sign.
REQ-018 SHALL round in S3 to nearest-even: increment when guard and (sticky or fraction LSB); inexact = guard or sticky.
REQ-019 SHALL, on rounding carry-out of the fraction, set the fraction to 0 and add 1 to the exponent.
REQ-020 SHALL, when the final exponent is at or above 2^EXP_W-1, output signed infinity (exponent all ones, fraction 0) with overflow and inexact set.
REQ-021 SHALL, when the final exponent is at or below 0, flush to signed zero with underflow and inexact set; no subnormals are produced.
REQ-022 SHALL hold out_r and out_flags stable while out_valid=1 and out_ready=0.

Reset
REQ-023 SHALL, while rst_n is low, clear all stage valid bits, out_valid, out_r, out_flags and flags_sticky to 0, and drive in_ready to 0.
REQ-024 SHALL discard in-flight beats when reset is asserted mid-operation; in_ready returns to 1 on the first clk edge after rst_n rises.

Configuration
REQ-025 SHALL use macro FP_NORM_ROUND_STICKY_FLAGS_EN; when defined, flags_sticky ORs in out_flags on every output handshake and clears on flags_clr; when clr and an update occur in the same cycle, the update wins.
REQ-026 SHALL, when FP_NORM_ROUND_STICKY_FLAGS_EN is undefined, tie flags_sticky to 0 and ignore flags_clr; datapath behaviour is identical in both builds.

Verification (EXP_W=8, MAN_W=23, M=28)
REQ-027 SHALL check: in_mant=28'h2000000, exp=127 -> out_r=32'h3F800000, flags=0, 3 cycles later; 28'h4000000, exp=127 -> 32'h40000000; 28'hE000000, exp=127 -> 32'hBF800000.
REQ-028 SHALL check: 28'h2000002, exp=127 (tie, even) -> 32'h3F800000, inexact; 28'h2000006 -> 32'h3F800002, inexact; 28'h3FFFFFE -> 32'h40000000, inexact.
REQ-029 SHALL check: 28'h4000000, exp=254 -> 32'h7F800000, flags=3'b101; 28'h0000004, exp=10 -> 32'h00000000, flags=3'b011.
REQ-030 SHALL check: out_ready low while 5 beats are offered -> exactly 3 accepted, in_ready low after that, in-order release once out_ready is high, no loss.
REQ-031 SHALL check: rst_n pulsed low with 3 beats in flight -> no out_valid afterwards, all outputs 0, next beat emerges after 3 cycles.
REQ-032 SHALL check (macro defined): overflow beat then flags_clr in the same cycle as an inexact beat handshake -> flags_sticky=3'b001.
